// File: rtl/program_loader_if.sv
// Byte-stream in / instruction-memory write port of the program loader.
// master = loader side, slave = receiver + memory side.
interface program_loader_if #(
    parameter int LEN      = 32,
    parameter int ADDR_LEN = 10
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                mem_we;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [LEN-1:0]      mem_wdata;

    modport master (input rx_data, rx_valid, output mem_we, mem_addr, mem_wdata);
    modport slave  (output rx_data, rx_valid, input mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/program_loader.sv
// Packs received bytes big-endian into words and writes them from address 0 until HALT_WORD.
// Optional trailing XOR checksum byte with PROGRAM_LOADER_CHECKSUM_EN defined.
module program_loader #(
    parameter int             LEN       = 32,
    parameter int             ADDR_LEN  = 10,
    parameter logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    program_loader_if.master bus,
    output logic             pipe_enable,
    output logic             busy,
    output logic             error
);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR, CHECK} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;
`endif

    localparam logic [ADDR_LEN-1:0] ADDR_MAX = '1;

    state_t         state;
    logic [LEN-9:0] shreg;
    logic [1:0]     byte_cnt;
    logic [LEN-1:0] word_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]     xor_acc;
`endif

    assign word_next = {shreg, bus.rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shreg         <= '0;
            byte_cnt      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            pipe_enable   <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_acc       <= '0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            // start wins over everything; a byte in the start cycle is dropped
            if (start) begin
                state        <= LOAD;
                shreg        <= '0;
                byte_cnt     <= '0;
                bus.mem_addr <= '0;
                pipe_enable  <= 1'b0;
                error        <= 1'b0;
                busy         <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                xor_acc      <= '0;
`endif
            end else begin
                case (state)
                    LOAD: if (bus.rx_valid) begin
                        shreg    <= word_next[LEN-9:0];
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        xor_acc  <= xor_acc ^ bus.rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            bus.mem_wdata <= word_next;
                            bus.mem_we    <= 1'b1;
                            state         <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (bus.mem_wdata == HALT_WORD) begin
                            busy <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            // a byte arriving right behind the halt word is the checksum
                            if (bus.rx_valid) begin
                                state       <= (bus.rx_data == xor_acc) ? DONE : ERROR;
                                pipe_enable <= (bus.rx_data == xor_acc);
                                error       <= (bus.rx_data != xor_acc);
                            end else begin
                                state <= CHECK;
                            end
`else
                            state       <= DONE;
                            pipe_enable <= 1'b1;
`endif
                        end else if (bus.mem_addr == ADDR_MAX) begin
                            state <= ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            bus.mem_addr <= bus.mem_addr + ADDR_LEN'(1);
                            state        <= LOAD;
                            // keep full-rate streams lossless: this byte starts the next word
                            if (bus.rx_valid) begin
                                shreg    <= word_next[LEN-9:0];
                                byte_cnt <= 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                                xor_acc  <= xor_acc ^ bus.rx_data;
`endif
                            end
                        end
                    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    CHECK: if (bus.rx_valid) begin
                        state       <= (bus.rx_data == xor_acc) ? DONE : ERROR;
                        pipe_enable <= (bus.rx_data == xor_acc);
                        error       <= (bus.rx_data != xor_acc);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Randomized program loads checked against a word-level model of the loader.
module tb_program_loader;
    localparam int          AL   = 10;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int S_LOAD = 0, S_DONE = 1, S_ERR = 2, S_CHECK = 3;

    logic clk = 1'b0;
    logic reset, start;
    logic pipe_enable, busy, error;

    program_loader_if #(.LEN(32), .ADDR_LEN(AL)) bus ();

    program_loader #(.LEN(32), .ADDR_LEN(AL), .HALT_WORD(HALT)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .pipe_enable(pipe_enable), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, we_cnt = 0;
    int weq[$];
    logic [AL+31:0] expq[$];
    logic [AL+31:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // every write pulse must match the next expected (addr, word)
    always @(negedge clk) if (bus.mem_we === 1'b1) begin
        we_cnt++;
        weq.push_back(cyc);
        if (expq.size() == 0) chk("extra_we", 32'(bus.mem_we), 32'd0);
        else begin
            mon_e = expq.pop_front();
            chk("waddr", 32'(bus.mem_addr), 32'(mon_e[AL+31:32]));
            chk("wdata", bus.mem_wdata, mon_e[31:0]);
        end
    end

    // word-level reference: which words get written and where the load ends up
    task automatic model(input logic [7:0] bs[$], output int st);
        logic [31:0] w;
        logic [7:0]  x;
        int nw;
        st = S_LOAD;
        x  = 8'h00;
        nw = bs.size() / 4;
        for (int k = 0; k < nw; k++) begin
            w = {bs[4*k], bs[4*k+1], bs[4*k+2], bs[4*k+3]};
            expq.push_back({AL'(k), w});
            for (int j = 0; j < 4; j++) x ^= bs[4*k+j];
            if (w == HALT) begin
                if (!CK) st = S_DONE;
                else if (bs.size() > 4*k+4) st = (bs[4*k+4] == x) ? S_DONE : S_ERR;
                else st = S_CHECK;
                return;
            end
            if (k == (1 << AL) - 1) begin
                st = S_ERR;
                return;
            end
        end
    endtask

    task automatic drive(input logic [7:0] bs[$], input int maxgap);
        foreach (bs[i]) begin
            repeat (int'($urandom_range(0, maxgap))) @(negedge clk);
            bus.rx_data  = bs[i];
            bus.rx_valid = 1'b1;
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start        = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'($urandom);
        @(negedge clk);
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        chk("st_drain", 32'(expq.size()), 32'd0);
        chk("st_busy", 32'(busy), 32'd1);
        chk("st_pipe", 32'(pipe_enable), 32'd0);
        chk("st_err", 32'(error), 32'd0);
        chk("st_addr", 32'(bus.mem_addr), 32'd0);
    endtask

    task automatic chk_status(input string tag, input int st);
        chk({tag, "_busy"}, 32'(busy), 32'(st == S_LOAD));
        chk({tag, "_pipe"}, 32'(pipe_enable), 32'(st == S_DONE));
        chk({tag, "_err"}, 32'(error), 32'(st == S_ERR));
        chk({tag, "_drain"}, 32'(expq.size()), 32'd0);
    endtask

    task automatic push_word(inout logic [7:0] bs[$], input logic [31:0] w);
        bs.push_back(w[31:24]); bs.push_back(w[23:16]);
        bs.push_back(w[15:8]);  bs.push_back(w[7:0]);
    endtask

    initial begin
        logic [7:0]  bs[$], b2[$];
        logic [31:0] w;
        logic [7:0]  x;
        int st, nw, base, wb;

        reset = 1'b1; start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk_status("rst", S_CHECK);
        reset = 1'b1;
        @(negedge clk);
        // bytes before any start are ignored
        bs = '{8'h12, 8'h34, 8'h56, 8'h78};
        drive(bs, 0);
        @(negedge clk);
        chk_status("idle", S_CHECK);

        // basic program, one byte per cycle
        pulse_start();
        base = we_cnt;
        bs = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        bs.push_back(8'h2D);
`endif
        model(bs, st);
        b2 = bs[0:3];
        drive(b2, 0);
        chk("t1_we0", 32'(bus.mem_we), 32'd1);
        b2 = bs[4:7];
        drive(b2, 0);
        chk("t1_we1", 32'(bus.mem_we), 32'd1);
        chk("t1_pipe_w", 32'(pipe_enable), 32'd0);
        @(negedge clk);
        chk("t1_pipe", 32'(pipe_enable), 32'(!CK));
        chk("t1_busy", 32'(busy), 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        @(negedge clk);
        chk("t1_pipe_ck", 32'(pipe_enable), 32'd0);
        b2 = bs[8:8];
        drive(b2, 0);
        chk("t1_pipe_ck2", 32'(pipe_enable), 32'd1);
`endif
        chk("t1_wecnt", 32'(we_cnt - base), 32'd2);
        chk_status("t1", st);

        // back-to-back stream: writes every 4 cycles
        pulse_start();
        wb = weq.size();
        base = cyc;
        bs.delete();
        x = 8'h00;
        for (int k = 0; k < 2; k++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            push_word(bs, w);
        end
        push_word(bs, HALT);
        foreach (bs[i]) x ^= bs[i];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        bs.push_back(x);
`endif
        model(bs, st);
        drive(bs, 0);
        repeat (2) @(negedge clk);
        chk("b2b_cnt", 32'(weq.size() - wb), 32'd3);
        for (int i = 0; i < 3 && wb + i < weq.size(); i++)
            chk("b2b_cyc", 32'(weq[wb+i] - base), 32'(4 * (i + 1)));
        chk_status("b2b", st);

        // restart mid-word: partial bytes must vanish
        pulse_start();
        bs = '{8'hAA, 8'hBB};
        drive(bs, 0);
        pulse_start();
        bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        bs.push_back(8'h44);
`endif
        model(bs, st);
        drive(bs, 1);
        repeat (2) @(negedge clk);
        chk_status("rs", st);

        // reset in the middle of a load
        pulse_start();
        bs.delete();
        push_word(bs, 32'h0A0B_0C0D);
        bs.push_back(8'h01); bs.push_back(8'h02);
        model(bs, st);
        drive(bs, 0);
        #2 reset = 1'b0;
        #1;
        chk("mr_we", 32'(bus.mem_we), 32'd0);
        chk("mr_addr", 32'(bus.mem_addr), 32'd0);
        chk("mr_wdata", bus.mem_wdata, 32'd0);
        chk_status("mr", S_CHECK);
        @(negedge clk);
        reset = 1'b1;
        base = we_cnt;
        bs.delete();
        push_word(bs, 32'h1234_5678);
        push_word(bs, HALT);
        drive(bs, 0);
        repeat (2) @(negedge clk);
        chk("mr_ign", 32'(we_cnt - base), 32'd0);
        chk_status("mr_idle", S_CHECK);

        // address overflow: 2^AL non-halt words
        pulse_start();
        base = we_cnt;
        bs.delete();
        for (int k = 0; k < (1 << AL); k++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            push_word(bs, w);
        end
        model(bs, st);
        drive(bs, 0);
        b2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        drive(b2, 0);
        repeat (2) @(negedge clk);
        chk("ov_cnt", 32'(we_cnt - base), 32'(1 << AL));
        chk_status("ov", st);
        pulse_start();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // checksum good / bad, checked with a gap before the checksum byte
        for (int t = 0; t < 2; t++) begin
            if (t == 1) pulse_start();
            bs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
            model(bs, st);
            drive(bs, 0);
            repeat (3) @(negedge clk);
            chk("ck_wait_pipe", 32'(pipe_enable), 32'd0);
            chk("ck_wait_busy", 32'(busy), 32'd0);
            b2 = '{(t == 0) ? 8'h04 : 8'h05};
            drive(b2, 0);
            chk("ck_pipe", 32'(pipe_enable), 32'(t == 0));
            chk("ck_err", 32'(error), 32'(t == 1));
        end
        pulse_start();
`endif

        // random programs with gaps, some aborted by a restart
        for (int s = 0; s < 25; s++) begin
            bs.delete();
            nw = int'($urandom_range(0, 5));
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                if (w == HALT) w = 32'h0;
                push_word(bs, w);
            end
            if ($urandom_range(0, 3) != 0) push_word(bs, HALT);
            x = 8'h00;
            foreach (bs[i]) x ^= bs[i];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            bs.push_back(($urandom_range(0, 1) == 1) ? x : (x ^ 8'h5A));
`endif
            if ($urandom_range(0, 3) == 0 && bs.size() > 0) begin
                nw = int'($urandom_range(0, bs.size() - 1));
                while (bs.size() > nw) void'(bs.pop_back());
                model(bs, st);
                drive(bs, 2);
            end else begin
                model(bs, st);
                drive(bs, 2);
                repeat (2) @(negedge clk);
                chk_status("rnd", st);
            end
            pulse_start();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the processor's instruction-memory port. It takes a byte stream from the serial receiver, packs the bytes into 32-bit instruction words, and writes them sequentially into instruction memory starting at address 0. It holds the pipeline disabled until a complete program, terminated by the halt word, has been written.

## Interface

Parameters:
- `LEN`, 32: instruction word width; must be 32.
- `ADDR_LEN`, 10: instruction-memory word-address width.
- `HALT_WORD`, 32'hFFFF_FFFF: end-of-program marker; it is written to memory as the last word.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins (or restarts) a load.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: `rx_data` is valid this cycle; one byte per high cycle; no backpressure.
- `mem_we` output 1: instruction-memory write enable, one-cycle pulse.
- `mem_addr` output ADDR_LEN: word address for the write.
- `mem_wdata` output LEN: word to write.
- `pipe_enable` output 1: high only when a program load has completed successfully.
- `busy` output 1: high in LOAD and WRITE.
- `error` output 1: high in ERROR.

## Operation

- States: IDLE, LOAD, WRITE, CHECK, DONE, ERROR. CHECK exists only with the macro defined (see Configuration).
- Reset: state=IDLE. All outputs 0: `mem_we`, `mem_addr`, `mem_wdata`, `pipe_enable`, `busy`, `error`. Byte counter, address counter and shift register are cleared.
- IDLE: `rx_valid` is ignored. `start` → LOAD, with address=0 and byte count=0.
- LOAD: each accepted byte shifts in big-endian (the first byte of a word lands in bits 31:24).
  - On the 4th byte: the assembled word is latched into `mem_wdata`, byte count returns to 0, and the state moves to WRITE.
- WRITE (exactly 1 cycle): `mem_we`=1 at `mem_addr`.
  - A byte arriving in this cycle is accepted as byte 0 of the next word; no byte is dropped.
  - Next state, checked in this order:
    1. If `mem_wdata`==HALT_WORD → DONE (or CHECK with the macro).
    2. Else if `mem_addr`==2^ADDR_LEN−1 → ERROR (overflow; no address wrap).
    3. Else `mem_addr`+1 → LOAD.
- DONE: `pipe_enable`=1 and is held.
- ERROR: `error`=1 and `pipe_enable`=0, both held.
- `start` in any state other than IDLE: immediate restart into LOAD.
  - Clears address and byte count, drops `pipe_enable` and `error`.
  - A byte arriving in the same cycle as `start` is discarded.
- `start` takes priority over `rx_valid` in every state.
- `rx_valid` is ignored in DONE and ERROR.
- Reset asserted mid-load: returns to IDLE at once. Words already written stay in memory; nothing is rewritten.

## Timing

- Registered outputs only; no combinational path from input to output.
- 4th byte sampled at edge N → `mem_we` high during cycle N+1 → next address visible from edge N+2.
- Maximum input rate: one byte every cycle, sustained, with no loss.
- `pipe_enable` rises the cycle after the WRITE of HALT_WORD, or after CHECK passes with the macro.
- `busy` covers LOAD and WRITE only. It is 0 in CHECK, DONE and ERROR.

## Configuration

- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - After the HALT_WORD write, the block enters CHECK and waits for one more byte.
  - That byte must equal the XOR of every payload byte received since `start`, including the halt bytes.
  - Match → DONE; mismatch → ERROR.
  - A running XOR register exists, cleared on `start`.
- Macro undefined: no CHECK state and no XOR register; WRITE of HALT_WORD goes directly to DONE.

## Test plan

- Reset, then `start`, then bytes 20 08 00 05 FF FF FF FF, one per cycle:
  - Writes 0x20080005 @0, then 0xFFFFFFFF @1.
  - `pipe_enable`=1 two cycles after the last byte; exactly 2 `mem_we` pulses.
- Back-to-back bytes with `rx_valid` held high for 12 cycles (3 words, the last being HALT): `mem_we` at cycles 5, 9, 13; addresses 0, 1, 2; no byte lost.
- ADDR_LEN=2, 4 non-halt words: 4th write at address 3, then `error`=1, `pipe_enable`=0, no 5th write. `start` then clears `error`.
- `start` after 2 bytes of a word, then a full program: first write lands at address 0 with the new bytes; the partial bytes are absent from it.
- `reset` low during LOAD: all outputs 0 asynchronously; subsequent `rx_valid` is ignored until `start`.
- With `PROGRAM_LOADER_CHECKSUM_EN`, word 0x01020304 + HALT:
  - Checksum 0x04 → DONE.
  - Checksum 0x05 → ERROR.
  - `pipe_enable` stays 0 until the checksum byte arrives.
